// File: rtl/clock_pkg.sv
// Shared BCD clock types, limits and helper functions for the time-of-day counter.
package clock_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEC_MAX    = 8'h59;
  localparam bcd2_t MIN_MAX    = 8'h59;
  localparam bcd2_t HOUR24_MAX = 8'h23;
  localparam bcd2_t HOUR12_MAX = 8'h12;
  localparam bcd2_t HOUR12_MIN = 8'h01;

  // Both nibbles must be decimal digits and the value must lie within [lo, hi].
  function automatic logic bcd2_valid(input bcd2_t x, input bcd2_t lo, input bcd2_t hi);
    return (x[7:4] <= 4'd9) && (x[3:0] <= 4'd9) && (x >= lo) && (x <= hi);
  endfunction

  function automatic bcd2_t bcd2_inc(input bcd2_t x);
    bcd2_t r;
    if (x[3:0] == 4'd9) r = {x[7:4] + 4'd1, 4'd0};
    else                r = {x[7:4], x[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter 00..MAX with load priority over count and a wrap carry.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = 8'h59
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  load,
  input  bcd2_t load_val,
  output bcd2_t val,
  output logic  carry
);

  bcd2_t val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load)                val_d = load_val;
    else if (en) begin
      if (val_q == MAX)      val_d = '0;
      else                   val_d = bcd2_inc(val_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign val   = val_q;
  assign carry = en && !load && (val_q == MAX);

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter (hh:mm:ss, packed BCD) in 12- or 24-hour mode with load and roll pulses.
// Optional alarm compare enabled by defining TIME_COUNTER_ALARM_EN.
module time_counter
  import clock_pkg::*;
#(
  parameter int H24 = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  sec_tick,
  input  logic  hold,
  input  logic  set_valid,
  input  bcd2_t set_hour,
  input  bcd2_t set_min,
  input  bcd2_t set_sec,
  input  logic  set_pm,
`ifdef TIME_COUNTER_ALARM_EN
  input  bcd2_t alarm_hour,
  input  bcd2_t alarm_min,
  input  logic  alarm_arm,
  output logic  alarm,
`endif
  output bcd2_t hour,
  output bcd2_t min,
  output bcd2_t sec,
  output logic  pm,
  output logic  min_roll,
  output logic  hour_roll,
  output logic  day_roll,
  output logic  set_err
);

  localparam bcd2_t HOUR_RST = (H24 != 0) ? 8'h00 : HOUR12_MAX;

  logic [1:0] rst_sync_q;
  logic       run;
  logic       load_valid, load_ok, tick_ok;
  logic       sec_carry, min_carry;
  bcd2_t      sec_val, min_val;
  bcd2_t      hour_q, hour_d;
  logic       pm_q, pm_d;
  logic       min_roll_q, hour_roll_q, day_roll_q, set_err_q;
  logic       day_roll_d;

  // Counting resumes only once reset release has crossed two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run = rst_sync_q[1];

  assign load_valid = bcd2_valid(set_sec, 8'h00, SEC_MAX)
                   && bcd2_valid(set_min, 8'h00, MIN_MAX)
                   && ((H24 != 0) ? bcd2_valid(set_hour, 8'h00, HOUR24_MAX)
                                  : bcd2_valid(set_hour, HOUR12_MIN, HOUR12_MAX));
  assign load_ok = set_valid && load_valid;
  assign tick_ok = sec_tick && !hold && !set_valid && run;

  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tick_ok),
    .load     (load_ok),
    .load_val (set_sec),
    .val      (sec_val),
    .carry    (sec_carry)
  );

  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sec_carry),
    .load     (load_ok),
    .load_val (set_min),
    .val      (min_val),
    .carry    (min_carry)
  );

  always_comb begin
    hour_d     = hour_q;
    pm_d       = pm_q;
    day_roll_d = 1'b0;
    if (load_ok) begin
      hour_d = set_hour;
      pm_d   = (H24 != 0) ? 1'b0 : set_pm;
    end else if (min_carry) begin
      if (H24 != 0) begin
        if (hour_q == HOUR24_MAX) begin
          hour_d     = '0;
          day_roll_d = 1'b1;
        end else begin
          hour_d = bcd2_inc(hour_q);
        end
      end else begin
        // 12 -> 01 is a plain wrap; 11 -> 12 flips am/pm and ends the day when leaving pm.
        if (hour_q == HOUR12_MAX) begin
          hour_d = HOUR12_MIN;
        end else if (hour_q == 8'h11) begin
          hour_d     = HOUR12_MAX;
          pm_d       = !pm_q;
          day_roll_d = pm_q;
        end else begin
          hour_d = bcd2_inc(hour_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_q      <= HOUR_RST;
      pm_q        <= 1'b0;
      min_roll_q  <= 1'b0;
      hour_roll_q <= 1'b0;
      day_roll_q  <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      hour_q      <= hour_d;
      pm_q        <= pm_d;
      min_roll_q  <= sec_carry;
      hour_roll_q <= min_carry;
      day_roll_q  <= day_roll_d;
      set_err_q   <= set_valid && !load_valid;
    end
  end

`ifdef TIME_COUNTER_ALARM_EN
  bcd2_t min_nxt;
  logic  alarm_q, alarm_d;

  // Only a tick that lands on sec=00 can match; loads never set sec_carry.
  always_comb begin
    min_nxt = min_carry ? 8'h00 : bcd2_inc(min_val);
    alarm_d = sec_carry && alarm_arm && (hour_d == alarm_hour) && (min_nxt == alarm_min);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_q <= 1'b0;
    else        alarm_q <= alarm_d;
  end
  assign alarm = alarm_q;
`endif

  assign hour      = hour_q;
  assign min       = min_val;
  assign sec       = sec_val;
  assign pm        = pm_q;
  assign min_roll  = min_roll_q;
  assign hour_roll = hour_roll_q;
  assign day_roll  = day_roll_q;
  assign set_err   = set_err_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter: a 24-hour and a 12-hour instance share stimulus.
module tb_time_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sec_tick = 1'b0;
  logic       hold = 1'b0;
  logic       set_valid = 1'b0;
  logic [7:0] set_hour = '0, set_min = '0, set_sec = '0;
  logic       set_pm = 1'b0;

  logic [7:0] h24, m24, s24, h12, m12, s12;
  logic       pm24, pm12;
  logic       mr24, hr24, dr24, se24, mr12, hr12, dr12, se12;
`ifdef TIME_COUNTER_ALARM_EN
  logic [7:0] alarm_hour = '0, alarm_min = '0;
  logic       alarm_arm = 1'b0;
  logic       al24, al12;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  time_counter #(.H24(1)) dut24 (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .hold(hold),
    .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_pm(set_pm),
`ifdef TIME_COUNTER_ALARM_EN
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_arm(alarm_arm), .alarm(al24),
`endif
    .hour(h24), .min(m24), .sec(s24), .pm(pm24),
    .min_roll(mr24), .hour_roll(hr24), .day_roll(dr24), .set_err(se24)
  );

  time_counter #(.H24(0)) dut12 (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .hold(hold),
    .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_pm(set_pm),
`ifdef TIME_COUNTER_ALARM_EN
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_arm(alarm_arm), .alarm(al12),
`endif
    .hour(h12), .min(m12), .sec(s12), .pm(pm12),
    .min_roll(mr12), .hour_roll(hr12), .day_roll(dr12), .set_err(se12)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
    set_valid = 1'b1; set_hour = h; set_min = m; set_sec = s; set_pm = p;
    cycle();
    set_valid = 1'b0;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    cycle();
    sec_tick = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({h24, m24, s24, pm24} !== {24'h000000, 1'b0}) begin
      fails++; $display("FAIL reset24 got %h:%h:%h pm=%b want 00:00:00 pm=0", h24, m24, s24, pm24);
    end
    tests++;
    if ({h12, m12, s12, pm12} !== {24'h120000, 1'b0}) begin
      fails++; $display("FAIL reset12 got %h:%h:%h pm=%b want 12:00:00 pm=0", h12, m12, s12, pm12);
    end
    tests++;
    if ({mr24, hr24, dr24, se24, mr12, hr12, dr12, se12} !== 8'h00) begin
      fails++; $display("FAIL reset_pulses got %b want 00000000", {mr24, hr24, dr24, se24, mr12, hr12, dr12, se12});
    end
    #10 rst_n = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic test_day_wrap();
    load(8'h23, 8'h59, 8'h58, 1'b0);
    tests++;
    if ({h24, m24, s24, mr24, hr24, dr24} !== {24'h235958, 3'b000}) begin
      fails++; $display("FAIL load_235958 got %h:%h:%h rolls=%b want 23:59:58 rolls=000", h24, m24, s24, {mr24, hr24, dr24});
    end
    tick();
    tests++;
    if ({h24, m24, s24, mr24, hr24, dr24} !== {24'h235959, 3'b000}) begin
      fails++; $display("FAIL tick_235959 got %h:%h:%h rolls=%b want 23:59:59 rolls=000", h24, m24, s24, {mr24, hr24, dr24});
    end
    tick();
    tests++;
    if ({h24, m24, s24, mr24, hr24, dr24} !== {24'h000000, 3'b111}) begin
      fails++; $display("FAIL day_wrap got %h:%h:%h rolls=%b want 00:00:00 rolls=111", h24, m24, s24, {mr24, hr24, dr24});
    end
    cycle();
    tests++;
    if ({h24, m24, s24, mr24, hr24, dr24} !== {24'h000000, 3'b000}) begin
      fails++; $display("FAIL day_wrap_end got %h:%h:%h rolls=%b want 00:00:00 rolls=000", h24, m24, s24, {mr24, hr24, dr24});
    end
    load(8'h09, 8'h09, 8'h59, 1'b0);
    tick();
    tests++;
    if ({h24, m24, s24, mr24, hr24, dr24} !== {24'h091000, 3'b100}) begin
      fails++; $display("FAIL bcd_carry got %h:%h:%h rolls=%b want 09:10:00 rolls=100", h24, m24, s24, {mr24, hr24, dr24});
    end
  endtask

  task automatic test_12h();
    load(8'h11, 8'h59, 8'h59, 1'b0);
    tick();
    tests++;
    if ({h12, m12, s12, pm12, hr12, dr12} !== {24'h120000, 3'b110}) begin
      fails++; $display("FAIL am_to_pm got %h:%h:%h pm=%b hr=%b dr=%b want 12:00:00 pm=1 hr=1 dr=0", h12, m12, s12, pm12, hr12, dr12);
    end
    load(8'h11, 8'h59, 8'h59, 1'b1);
    tick();
    tests++;
    if ({h12, m12, s12, pm12, dr12} !== {24'h120000, 2'b01}) begin
      fails++; $display("FAIL pm_to_am got %h:%h:%h pm=%b dr=%b want 12:00:00 pm=0 dr=1", h12, m12, s12, pm12, dr12);
    end
    tests++;
    if (pm24 !== 1'b0) begin
      fails++; $display("FAIL pm24_held got %b want 0", pm24);
    end
    load(8'h12, 8'h59, 8'h59, 1'b0);
    tick();
    tests++;
    if ({h12, m12, s12, pm12, dr12} !== {24'h010000, 2'b00}) begin
      fails++; $display("FAIL twelve_to_one got %h:%h:%h pm=%b dr=%b want 01:00:00 pm=0 dr=0", h12, m12, s12, pm12, dr12);
    end
  endtask

  task automatic test_set_err();
    load(8'h10, 8'h20, 8'h30, 1'b0);
    load(8'h10, 8'h20, 8'h5A, 1'b0);
    tests++;
    if ({se24, h24, m24, s24} !== {1'b1, 24'h102030}) begin
      fails++; $display("FAIL err_sec got set_err=%b %h:%h:%h want 1 10:20:30", se24, h24, m24, s24);
    end
    cycle();
    tests++;
    if (se24 !== 1'b0) begin
      fails++; $display("FAIL err_pulse_len got %b want 0", se24);
    end
    load(8'h24, 8'h20, 8'h30, 1'b0);
    tests++;
    if ({se24, se12, h24, m24, s24} !== {2'b11, 24'h102030}) begin
      fails++; $display("FAIL err_hour got set_err=%b/%b %h:%h:%h want 1/1 10:20:30", se24, se12, h24, m24, s24);
    end
    load(8'h00, 8'h20, 8'h30, 1'b0);
    tests++;
    if ({se24, se12, h24, h12} !== {2'b01, 8'h00, 8'h10}) begin
      fails++; $display("FAIL err_hour12_zero got set_err=%b/%b hour=%h/%h want 0/1 00/10", se24, se12, h24, h12);
    end
  endtask

  task automatic test_coincide();
    load(8'h01, 8'h02, 8'h03, 1'b0);
    sec_tick = 1'b1;
    load(8'h10, 8'h20, 8'h30, 1'b0);
    sec_tick = 1'b0;
    tests++;
    if ({h24, m24, s24, mr24, hr24, dr24, se24} !== {24'h102030, 4'b0000}) begin
      fails++; $display("FAIL load_wins got %h:%h:%h flags=%b want 10:20:30 flags=0000", h24, m24, s24, {mr24, hr24, dr24, se24});
    end
    sec_tick = 1'b1;
    load(8'h10, 8'h20, 8'h60, 1'b0);
    sec_tick = 1'b0;
    tests++;
    if ({h24, m24, s24, se24} !== {24'h102030, 1'b1}) begin
      fails++; $display("FAIL bad_load_wins got %h:%h:%h set_err=%b want 10:20:30 1", h24, m24, s24, se24);
    end
    hold = 1'b1;
    sec_tick = 1'b1;
    repeat (5) cycle();
    hold = 1'b0;
    tests++;
    if ({h24, m24, s24} !== 24'h102030) begin
      fails++; $display("FAIL hold got %h:%h:%h want 10:20:30", h24, m24, s24);
    end
    repeat (3) cycle();
    sec_tick = 1'b0;
    tests++;
    if ({h24, m24, s24} !== 24'h102033) begin
      fails++; $display("FAIL level_tick got %h:%h:%h want 10:20:33", h24, m24, s24);
    end
    hold = 1'b1;
    load(8'h05, 8'h06, 8'h07, 1'b0);
    hold = 1'b0;
    tests++;
    if ({h24, m24, s24} !== 24'h050607) begin
      fails++; $display("FAIL load_under_hold got %h:%h:%h want 05:06:07", h24, m24, s24);
    end
  endtask

  task automatic test_reset_mid();
    load(8'h07, 8'h45, 8'h11, 1'b0);
    tick();
    tests++;
    if ({h24, m24, s24} !== 24'h074512) begin
      fails++; $display("FAIL pre_reset got %h:%h:%h want 07:45:12", h24, m24, s24);
    end
    sec_tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({h24, m24, s24, h12} !== {24'h000000, 8'h12}) begin
      fails++; $display("FAIL async_reset got %h:%h:%h h12=%h want 00:00:00 h12=12", h24, m24, s24, h12);
    end
    #2 rst_n = 1'b1;
    cycle();
    cycle();
    tests++;
    if ({h24, m24, s24, mr24} !== {24'h000000, 1'b0}) begin
      fails++; $display("FAIL sync_window got %h:%h:%h min_roll=%b want 00:00:00 0", h24, m24, s24, mr24);
    end
    cycle();
    sec_tick = 1'b0;
    tests++;
    if ({h24, m24, s24} !== 24'h000001) begin
      fails++; $display("FAIL resume got %h:%h:%h want 00:00:01", h24, m24, s24);
    end
  endtask

`ifdef TIME_COUNTER_ALARM_EN
  task automatic test_alarm();
    alarm_hour = 8'h06; alarm_min = 8'h30; alarm_arm = 1'b1;
    load(8'h06, 8'h30, 8'h00, 1'b0);
    tests++;
    if (al24 !== 1'b0) begin
      fails++; $display("FAIL alarm_on_load got %b want 0", al24);
    end
    load(8'h06, 8'h29, 8'h59, 1'b0);
    tick();
    tests++;
    if ({al24, al12, h24, m24, s24} !== {2'b11, 24'h063000}) begin
      fails++; $display("FAIL alarm_fire got %b/%b %h:%h:%h want 1/1 06:30:00", al24, al12, h24, m24, s24);
    end
    cycle();
    tests++;
    if (al24 !== 1'b0) begin
      fails++; $display("FAIL alarm_len got %b want 0", al24);
    end
    alarm_arm = 1'b0;
    load(8'h06, 8'h29, 8'h59, 1'b0);
    tick();
    tests++;
    if (al24 !== 1'b0) begin
      fails++; $display("FAIL alarm_disarmed got %b want 0", al24);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_day_wrap();
    test_12h();
    test_set_err();
    test_coincide();
    test_reset_mid();
`ifdef TIME_COUNTER_ALARM_EN
    test_alarm();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter H24, default 1: 1 selects 24-hour mode (hours 00-23); 0 selects 12-hour mode (hours 01-12 plus pm flag).
REQ-002 clk  input  1  system clock; all logic in this single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 sec_tick  input  1  one-clk-cycle pulse per second from the upstream divider stage; a level held high counts once per clk cycle.
REQ-005 hold  input  1  when high, sec_tick is ignored (time frozen).
REQ-006 set_valid  input  1  load request for set_hour/set_min/set_sec; accepted in any cycle it is high.
REQ-007 set_hour, set_min, set_sec  input  8 each  packed 2-digit BCD load values; set_pm input 1 (12-hour mode only).
REQ-008 hour, min, sec  output  8 each  current time, packed 2-digit BCD, registered; pm output 1.
REQ-009 min_roll, hour_roll, day_roll  output  1 each  one-cycle pulses on sec 59->00, min 59->00, and day wrap.
REQ-010 set_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-011 On an accepted sec_tick (sec_tick=1, hold=0, set_valid=0), time advances by exactly one second; outputs update on the next clk edge (latency 1 cycle).
REQ-012 sec and min count 00..59 in BCD; the units digit wraps 9->0 and carries into tens; the tens digit wraps 5->0 and carries onward.
REQ-013 H24=1: hour counts 00..23; 23:59:59 -> 00:00:00 asserts day_roll; pm is held 0.
REQ-014 H24=0: hour sequence 12,01,..,11,12; 11:59:59 -> 12:00:00 toggles pm; pm 1->0 on that transition asserts day_roll.
REQ-015 Roll pulses are asserted in the same cycle the wrapped value appears on the outputs; all cascaded pulses assert together (e.g. day wrap asserts min_roll, hour_roll and day_roll).
REQ-016 Load validity: each BCD nibble <= 9, sec/min <= 0x59, hour <= 0x23 (H24=1) or 0x01..0x12 (H24=0).
REQ-017 A valid load replaces hour/min/sec/pm on the next edge; no roll pulses are generated by a load.
REQ-018 An invalid load leaves time unchanged and pulses set_err for one cycle.
REQ-019 If set_valid and sec_tick coincide, the load wins and the tick is discarded, whether the load is valid or invalid.
REQ-020 hold has no effect on loads.

Reset
REQ-021 rst_n low asynchronously forces: 24-hour mode 00:00:00; 12-hour mode 12:00:00 with pm=0; all pulses and set_err 0.
REQ-022 Release of rst_n is synchronized internally (two-flop) before counting resumes; a sec_tick within the first 2 cycles after release is ignored.
REQ-023 Reset mid-load or mid-tick discards the operation entirely.

Configuration
REQ-024 Macro TIME_COUNTER_ALARM_EN defined: adds inputs alarm_hour (8), alarm_min (8), alarm_arm (1) and output alarm (1).
REQ-025 With the macro, alarm pulses for one cycle when a tick-driven advance produces hour:min equal to alarm_hour:alarm_min with sec=00 while alarm_arm=1. Loads never trigger alarm. Reset value of alarm is 0.
REQ-026 Without the macro, the alarm ports and logic are absent; all other behaviour is identical.

Structure
REQ-027 Shared package clock_pkg: bcd2_t (8-bit packed BCD) typedef; constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR24_MAX=8'h23, HOUR12_MAX=8'h12, HOUR12_MIN=8'h01; bcd2_valid function.
REQ-028 Sub-module bcd2_counter (parameterized max value, enable in, wrap-carry out, load port) instantiated for sec and min; hour logic stays local because of the 12/24 mode.

Verification
REQ-029 Load 23:59:58 (H24=1), two ticks -> 23:59:59, then 00:00:00 with min_roll, hour_roll and day_roll all high for exactly one cycle.
REQ-030 H24=0: load 11:59:59 pm=0, one tick -> 12:00:00 pm=1, no day_roll; load 11:59:59 pm=1, one tick -> 12:00:00 pm=0, day_roll=1.
REQ-031 Load sec=0x5A, then separately hour=0x24 (H24=1) -> set_err pulse each time; time unchanged.
REQ-032 set_valid(10:20:30) coincident with sec_tick -> 10:20:30 next cycle; no advance, no roll pulses; hold=1 with 5 ticks -> time unchanged.
REQ-033 rst_n pulled low asynchronously mid-count at 07:45:12 -> outputs 00:00:00 immediately; a tick within 2 cycles of release is ignored.
REQ-034 With TIME_COUNTER_ALARM_EN: alarm 06:30, arm=1, load 06:29:59, one tick -> alarm pulses 1 cycle; with arm=0 -> no pulse.
